// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: operand-fetch pipeline stage between IF and EX.
// Decodes the IF/OF instruction, drives the register file read ports, resolves
// operands, detects RAW hazards (stalling fetch) and holds the OF/EX register.
// Optional feature macro: OF_FORWARD_EN adds MA/RW result forwarding, so that
// only EX-stage producers and MA-stage loads cause a stall.
module operand_fetch_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        if_stall,
    input  logic        flush,
    output logic [3:0]  rf_rs1,
    output logic [3:0]  rf_rs2,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    input  logic        ma_wb,
    input  logic        ma_is_ld,
    input  logic [3:0]  ma_rd,
    input  logic [31:0] ma_result,
    input  logic        rw_wb,
    input  logic [3:0]  rw_rd,
    input  logic [31:0] rw_data,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_st_data,
    output logic [31:0] ex_br_target,
    output logic [4:0]  ex_opcode,
    output logic [3:0]  ex_rd,
    output logic        ex_wb,
    output logic        ex_is_ld,
    output logic        ex_is_st,
    output logic        ex_is_imm
);

    logic [4:0]  opcode;
    logic        imm_flag;
    logic [3:0]  rd_field;
    logic [3:0]  rs1_field;
    logic [3:0]  rs2_field;
    logic [15:0] imm_field;
    logic [1:0]  modifier;
    logic [26:0] offset;

    logic        is_ld, is_st, is_ret, is_call;
    logic        use_src1, use_src2;
    logic [3:0]  src1, src2;
    logic        dec_wb;
    logic [3:0]  dec_rd;
    logic [31:0] imm_val;
    logic [31:0] br_target;
    logic [31:0] op1_val, op2_val;
    logic        hz1, hz2, hazard;

    assign opcode    = if_instr[31:27];
    assign imm_flag  = if_instr[26];
    assign rd_field  = if_instr[25:22];
    assign rs1_field = if_instr[21:18];
    assign rs2_field = if_instr[17:14];
    assign imm_field = if_instr[15:0];
    assign modifier  = if_instr[17:16];
    assign offset    = if_instr[26:0];

    // Decode which sources are read, the destination, and the immediate format
    always_comb begin
        is_ld    = (opcode == 5'b01110);
        is_st    = (opcode == 5'b01111);
        is_call  = (opcode == 5'b10011);
        is_ret   = (opcode == 5'b10100);
        use_src1 = (opcode <= 5'b00111) ||
                   ((opcode >= 5'b01010) && (opcode <= 5'b01100)) ||
                   is_ld || is_st || is_ret;
        src1     = is_ret ? 4'd15 : rs1_field;
        use_src2 = ((!imm_flag) && (opcode <= 5'b01100)) || is_st;
        src2     = is_st ? rd_field : rs2_field;
        dec_wb   = (opcode <= 5'b00100) ||
                   ((opcode >= 5'b00110) && (opcode <= 5'b01100)) ||
                   is_ld || is_call;
        dec_rd   = is_call ? 4'd15 : rd_field;
        case (modifier)
            2'b01:   imm_val = {16'h0000, imm_field};
            2'b10:   imm_val = {imm_field, 16'h0000};
            default: imm_val = {{16{imm_field[15]}}, imm_field};
        endcase
        br_target = if_pc + {{3{offset[26]}}, offset, 2'b00};
    end

`ifdef OF_FORWARD_EN
    // Take the youngest in-flight value for each source; MA beats RW, MA loads are not ready yet
    always_comb begin
        op1_val = rf_rd1;
        if (ma_wb && !ma_is_ld && (ma_rd == src1))
            op1_val = ma_result;
        else if (rw_wb && (rw_rd == src1))
            op1_val = rw_data;
        op2_val = rf_rd2;
        if (ma_wb && !ma_is_ld && (ma_rd == src2))
            op2_val = ma_result;
        else if (rw_wb && (rw_rd == src2))
            op2_val = rw_data;
    end

    // A source is blocked by any EX producer, or by a load that is still in MA
    always_comb begin
        hz1    = (ex_valid && ex_wb && (ex_rd == src1)) || (ma_wb && ma_is_ld && (ma_rd == src1));
        hz2    = (ex_valid && ex_wb && (ex_rd == src2)) || (ma_wb && ma_is_ld && (ma_rd == src2));
        hazard = (use_src1 && hz1) || (use_src2 && hz2);
    end
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ma_is_ld, ma_result, rw_wb, rw_rd, rw_data};

    // Operands come straight from the register file, whose write-through covers RW
    always_comb begin
        op1_val = rf_rd1;
        op2_val = rf_rd2;
    end

    // Without forwarding any producer still in EX or MA blocks the source
    always_comb begin
        hz1    = (ex_valid && ex_wb && (ex_rd == src1)) || (ma_wb && (ma_rd == src1));
        hz2    = (ex_valid && ex_wb && (ex_rd == src2)) || (ma_wb && (ma_rd == src2));
        hazard = (use_src1 && hz1) || (use_src2 && hz2);
    end
`endif

    // Combinational outputs are held at zero while reset is asserted
    assign if_stall = rst_n && if_valid && hazard && !flush;
    assign rf_rs1   = rst_n ? src1 : 4'd0;
    assign rf_rs2   = rst_n ? src2 : 4'd0;

    // OF/EX register: flush and stall both insert a bubble, otherwise capture the decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_wb        <= 1'b0;
            ex_is_ld     <= 1'b0;
            ex_is_st     <= 1'b0;
            ex_is_imm    <= 1'b0;
            ex_opcode    <= 5'd0;
            ex_rd        <= 4'd0;
            ex_pc        <= 32'd0;
            ex_a         <= 32'd0;
            ex_b         <= 32'd0;
            ex_st_data   <= 32'd0;
            ex_br_target <= 32'd0;
        end else begin
            ex_valid <= 1'b0;
            ex_wb    <= 1'b0;
            ex_is_ld <= 1'b0;
            ex_is_st <= 1'b0;
            if (!flush && !if_stall) begin
                ex_valid     <= if_valid;
                ex_wb        <= if_valid && dec_wb;
                ex_is_ld     <= if_valid && is_ld;
                ex_is_st     <= if_valid && is_st;
                ex_is_imm    <= imm_flag;
                ex_opcode    <= opcode;
                ex_rd        <= dec_rd;
                ex_pc        <= if_pc;
                ex_a         <= op1_val;
                ex_b         <= imm_flag ? imm_val : op2_val;
                ex_st_data   <= op2_val;
                ex_br_target <= br_target;
            end
        end
    end

endmodule
